// File: rtl/mem_port_sched.sv
// Single-outstanding arbiter for the shared 128-bit line memory port (D > I > M with aging).
// Optional WAIT-state timeout with sticky err_o is enabled by defining MEM_SCHED_TIMEOUT_EN.
module mem_port_sched #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int MAX_WAIT    = 15,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_cs_i,
  input  logic              i_we_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [LINE_W-1:0] i_wdata_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_rvalid_o,
  input  logic              d_cs_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_rvalid_o,
  input  logic              m_cs_i,
  input  logic              m_we_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [LINE_W-1:0] m_wdata_i,
  output logic [LINE_W-1:0] m_rdata_o,
  output logic              m_rvalid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LINE_W-1:0] wdata_o,
  output logic              we_o,
  output logic              cs_o,
  input  logic              handshaked_i,
  input  logic [LINE_W-1:0] rdata_i,
  input  logic              rvalid_i,
  output logic [2:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among pending requesters
  // REQ   | cs_o high, waiting for handshaked_i
  // WAIT  | request accepted, waiting for rvalid_i
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [1:0]            state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0][AGE_W-1:0] age_q, age_d;

  logic [2:0]  req, aged, cand, win;
  logic        start, mem_done, done, to_fire;
  logic [LINE_W-1:0] rdata_mux;

  // Bit order everywhere is {m, i, d}, so index 0 is the highest fixed priority.
  assign req = {m_cs_i, i_cs_i, d_cs_i};

  always_comb begin
    for (int k = 0; k < 3; k++) aged[k] = req[k] && (age_q[k] == AGE_MAX);
    cand = (|aged) ? aged : req;
    win  = cand[0] ? 3'b001 : cand[1] ? 3'b010 : cand[2] ? 3'b100 : 3'b000;
  end

  assign start    = (state_q == ST_IDLE) && (|req);
  assign mem_done = ((state_q == ST_REQ) && handshaked_i && rvalid_i) ||
                    ((state_q == ST_WAIT) && rvalid_i);
  assign done     = mem_done || to_fire;

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          cs_d    = 1'b1;
          grant_d = win;
          if (win[0]) begin
            we_d = d_we_i; addr_d = d_addr_i; wdata_d = d_wdata_i;
          end else if (win[1]) begin
            we_d = i_we_i; addr_d = i_addr_i; wdata_d = i_wdata_i;
          end else begin
            we_d = m_we_i; addr_d = m_addr_i; wdata_d = m_wdata_i;
          end
        end
      end
      ST_REQ: begin
        if (handshaked_i) begin
          cs_d = 1'b0;
          if (rvalid_i) begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
        grant_d = 3'b000;
      end
    endcase
  end

  // A requester ages only while it is visibly waiting: pending, not owning, not just chosen.
  always_comb begin
    age_d = age_q;
    for (int k = 0; k < 3; k++) begin
      if (!req[k] || grant_q[k] || (start && win[k])) age_d[k] = '0;
      else if (age_q[k] != AGE_MAX)                    age_d[k] = age_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 3'b000;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      age_q   <= age_d;
    end
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  // Down-counter loaded as the request is accepted; terminal count marks the last WAIT cycle.
  assign to_fire = (state_q == ST_WAIT) && !rvalid_i && (to_q == '0);

  always_comb begin
    to_d  = to_q;
    err_d = err_q || to_fire;
    if ((state_q == ST_REQ) && handshaked_i) to_d = TO_W'(TIMEOUT_CYC - 1);
    else if ((state_q == ST_WAIT) && (to_q != '0)) to_d = to_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign to_fire = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign rdata_mux  = to_fire ? '0 : rdata_i;
  assign d_rdata_o  = rdata_mux;
  assign i_rdata_o  = rdata_mux;
  assign m_rdata_o  = rdata_mux;
  assign d_rvalid_o = grant_q[0] && done;
  assign i_rvalid_o = grant_q[1] && done;
  assign m_rvalid_o = grant_q[2] && done;

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;
  assign cs_o    = cs_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule
